// File: rtl/branch_ctrl_if.sv
// Decode-to-branch-controller handshake bundle.
// Latency: none, wires only.
// Backpressure: br_ready from the controller holds the branch at decode until accepted.
//
// Ports carried: br_valid/br_ready handshake, br_type (01 EQ, 10 GT, 11 LT, 00 jump),
// br_pc (branch PC), br_offset (signed two's-complement offset).
interface branch_ctrl_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  br_valid;
    logic                  br_ready;
    logic [1:0]            br_type;
    logic [DATA_WIDTH-1:0] br_pc;
    logic [DATA_WIDTH-1:0] br_offset;

    // decode side
    modport master (
        output br_valid, br_type, br_pc, br_offset,
        input  br_ready
    );

    // controller side
    modport slave (
        input  br_valid, br_type, br_pc, br_offset,
        output br_ready
    );
endinterface

// File: rtl/branch_ctrl.sv
// Sequences one branch at a time through operand wait, a single compare cycle and a timed flush.
// Latency: accept t, operands t+1, EVAL t+2, redirect t+3, ready again t+3+FLUSH_CYCLES (t+3 if not taken).
// Backpressure: br_ready only in IDLE; stall held while a branch is in flight; waits on op_valid indefinitely.
//
// Ports: clk/rst (async active-high); br (decode handshake, slave side);
// op_valid/op_a/op_b forwarded operands; kill aborts the in-flight branch; cnt_clr clears counters;
// cmp_data_1/cmp_data_2/cmp_control drive the external comparator, cmp_branch is its result;
// stall, redirect/redirect_pc, flush steer the pipeline; taken_cnt/branch_cnt are saturating counters.
module branch_ctrl #(
    parameter int DATA_WIDTH   = 16,
    parameter int PC_INC       = 1,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_ctrl_if.slave          br,
    input  logic                  op_valid,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    input  logic                  kill,
    input  logic                  cnt_clr,
    output logic [DATA_WIDTH-1:0] cmp_data_1,
    output logic [DATA_WIDTH-1:0] cmp_data_2,
    output logic [1:0]            cmp_control,
    input  logic                  cmp_branch,
    output logic                  stall,
    output logic                  redirect,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  flush,
    output logic [CNT_WIDTH-1:0]  taken_cnt,
    output logic [CNT_WIDTH-1:0]  branch_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_OPS,
        S_EVAL,
        S_FLUSH
    } state_t;

    localparam logic [DATA_WIDTH-1:0] PC_INC_W   = DATA_WIDTH'(PC_INC);
    localparam logic [3:0]            FLUSH_LOAD = 4'(FLUSH_CYCLES);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX    = '1;

    state_t                state, state_nxt;
    logic [1:0]            type_q;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] off_q;
    logic [3:0]            flush_cnt;
    logic                  accept;
    logic                  taken;
    logic                  eval_ok;
    logic [DATA_WIDTH-1:0] target;

    assign accept  = br.br_valid && br.br_ready;
    // Unconditional jumps bypass the comparator result.
    assign taken   = (type_q == 2'b00) || cmp_branch;
    // An EVAL that is killed leaves no architectural trace.
    assign eval_ok = (state == S_EVAL) && !kill;
    // Wraps modulo 2^DATA_WIDTH by construction.
    assign target  = pc_q + PC_INC_W + off_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; kill is ignored in IDLE so a same-cycle accept still lands.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (accept) state_nxt = S_WAIT_OPS;
            S_WAIT_OPS: begin
                if (kill)          state_nxt = S_IDLE;
                else if (op_valid) state_nxt = S_EVAL;
            end
            S_EVAL: begin
                if (kill)       state_nxt = S_IDLE;
                else if (taken) state_nxt = S_FLUSH;
                else            state_nxt = S_IDLE;
            end
            S_FLUSH:    if (kill || flush_cnt == 4'd1) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        br.br_ready = (state == S_IDLE);
        stall       = (state != S_IDLE);
        cmp_control = (state == S_EVAL) ? type_q : 2'b00;
        flush       = (state == S_FLUSH);
        // The counter still holds its load value only in the first FLUSH cycle.
        redirect    = (state == S_FLUSH) && (flush_cnt == FLUSH_LOAD);
    end

    // Branch fields, operands, target and flush timer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            type_q      <= '0;
            pc_q        <= '0;
            off_q       <= '0;
            cmp_data_1  <= '0;
            cmp_data_2  <= '0;
            redirect_pc <= '0;
            flush_cnt   <= '0;
        end else begin
            if (accept) begin
                type_q <= br.br_type;
                pc_q   <= br.br_pc;
                off_q  <= br.br_offset;
            end
            if (state == S_WAIT_OPS && op_valid && !kill) begin
                cmp_data_1 <= op_a;
                cmp_data_2 <= op_b;
            end
            if (eval_ok && taken) begin
                redirect_pc <= target;
                flush_cnt   <= FLUSH_LOAD;
            end else if (state == S_FLUSH) begin
                flush_cnt <= flush_cnt - 4'd1;
            end
        end
    end

    // Saturating performance counters; a clear overrides any increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taken_cnt  <= '0;
            branch_cnt <= '0;
        end else if (cnt_clr) begin
            taken_cnt  <= '0;
            branch_cnt <= '0;
        end else if (eval_ok) begin
            if (branch_cnt != CNT_MAX)         branch_cnt <= branch_cnt + 1'b1;
            if (taken && taken_cnt != CNT_MAX) taken_cnt  <= taken_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// Randomized bench for branch_ctrl with a transaction-level reference model.
// Latency: checks every cycle of each branch against the documented timeline.
// Backpressure: waits (bounded) on br_ready before presenting each branch.
module tb_branch_ctrl;
    localparam int DW   = 16;
    localparam int FC   = 2;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_ctrl_if #(.DATA_WIDTH(DW)) bif ();

    logic          op_valid, kill, cnt_clr, cmp_branch, stall, redirect, flush;
    logic [DW-1:0] op_a, op_b, cmp_data_1, cmp_data_2, redirect_pc;
    logic [1:0]    cmp_control;
    logic [CW-1:0] taken_cnt, branch_cnt;

    branch_ctrl #(
        .DATA_WIDTH(DW), .PC_INC(1), .FLUSH_CYCLES(FC), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .br(bif),
        .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .kill(kill), .cnt_clr(cnt_clr),
        .cmp_data_1(cmp_data_1), .cmp_data_2(cmp_data_2), .cmp_control(cmp_control),
        .cmp_branch(cmp_branch), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .flush(flush),
        .taken_cnt(taken_cnt), .branch_cnt(branch_cnt)
    );

    // Unsigned comparator standing in for the execute-stage unit.
    always_comb begin
        case (cmp_control)
            2'b01:   cmp_branch = (cmp_data_1 == cmp_data_2);
            2'b10:   cmp_branch = (cmp_data_1 >  cmp_data_2);
            2'b11:   cmp_branch = (cmp_data_1 <  cmp_data_2);
            default: cmp_branch = 1'b0;
        endcase
    end

    int            n_chk  = 0;
    int            n_pass = 0;
    int            m_taken = 0;
    int            m_branch = 0;
    logic [DW-1:0] m_rpc = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_taken_cnt"}, 32'(taken_cnt), m_taken);
        chk({tag, "_branch_cnt"}, 32'(branch_cnt), m_branch);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50 && bif.br_ready !== 1'b1; i++) step();
        chk("idle_ready", 32'(bif.br_ready), 1);
    endtask

    // kill_at: 0 none, 1 WAIT_OPS, 2 EVAL, 3 first FLUSH cycle
    task automatic run_branch(input logic [1:0] ty, input logic [DW-1:0] pc, input logic [DW-1:0] off,
                              input logic [DW-1:0] a, input logic [DW-1:0] b, input int waits,
                              input int kill_at, input bit clr_eval, input bit kill_on_accept);
        logic          tk;
        logic [DW-1:0] tgt;
        tk  = (ty == 2'b00) || (ty == 2'b01 && a == b) || (ty == 2'b10 && a > b) || (ty == 2'b11 && a < b);
        tgt = pc + off + 16'd1;
        wait_idle();
        bif.br_valid = 1'b1; bif.br_type = ty; bif.br_pc = pc; bif.br_offset = off;
        kill = kill_on_accept;
        // Junk operands marked valid in the accept cycle must be ignored.
        op_valid = 1'b1; op_a = 16'(~a); op_b = 16'($urandom);
        step();
        bif.br_valid = 1'b0; bif.br_type = 2'($urandom); bif.br_pc = 16'($urandom); bif.br_offset = 16'($urandom);
        kill = 1'b0; op_valid = 1'b0;
        chk("accept_ready", 32'(bif.br_ready), 0);
        chk("wait_stall", 32'(stall), 1);
        if (kill_at == 1) begin
            kill = 1'b1; step(); kill = 1'b0;
            chk("kill_wait_ready", 32'(bif.br_ready), 1);
            chk("kill_wait_stall", 32'(stall), 0);
            chk_cnt("kill_wait");
            return;
        end
        repeat (waits) begin
            op_a = 16'($urandom); op_b = 16'($urandom);
            step();
            chk("opwait_stall", 32'(stall), 1);
            chk("opwait_ctrl", 32'(cmp_control), 0);
        end
        op_valid = 1'b1; op_a = a; op_b = b;
        step();
        op_valid = 1'b0; op_a = 16'($urandom); op_b = 16'($urandom);
        chk("eval_ctrl", 32'(cmp_control), 32'(ty));
        chk("eval_d1", 32'(cmp_data_1), 32'(a));
        chk("eval_d2", 32'(cmp_data_2), 32'(b));
        chk("eval_stall", 32'(stall), 1);
        kill = (kill_at == 2); cnt_clr = clr_eval;
        step();
        kill = 1'b0; cnt_clr = 1'b0;
        if (clr_eval) begin
            m_taken = 0; m_branch = 0;
        end else if (kill_at != 2) begin
            m_branch = (m_branch < CMAX) ? m_branch + 1 : CMAX;
            if (tk) m_taken = (m_taken < CMAX) ? m_taken + 1 : CMAX;
        end
        chk_cnt("post_eval");
        if (kill_at == 2 || !tk) begin
            chk("nt_ready", 32'(bif.br_ready), 1);
            chk("nt_redirect", 32'(redirect), 0);
            chk("nt_flush", 32'(flush), 0);
            chk("nt_rpc", 32'(redirect_pc), 32'(m_rpc));
            return;
        end
        if (!clr_eval || kill_at != 2) m_rpc = tgt;
        chk("redirect", 32'(redirect), 1);
        chk("redirect_pc", 32'(redirect_pc), 32'(tgt));
        chk("flush_first", 32'(flush), 1);
        chk("flush_stall", 32'(stall), 1);
        if (kill_at == 3) begin
            kill = 1'b1; step(); kill = 1'b0;
            chk("kill_flush_flush", 32'(flush), 0);
            chk("kill_flush_redirect", 32'(redirect), 0);
            chk("kill_flush_ready", 32'(bif.br_ready), 1);
            return;
        end
        for (int k = 1; k < FC; k++) begin
            step();
            chk("flush_hold_redirect", 32'(redirect), 0);
            chk("flush_hold", 32'(flush), 1);
            chk("flush_hold_ready", 32'(bif.br_ready), 0);
        end
        step();
        chk("flush_done_ready", 32'(bif.br_ready), 1);
        chk("flush_done_flush", 32'(flush), 0);
        chk("flush_done_stall", 32'(stall), 0);
    endtask

    task automatic run_random(input bit allow_clr);
        logic [1:0]    ty;
        logic [DW-1:0] a, b;
        int            r, ka;
        ty = 2'($urandom_range(0, 3));
        a  = 16'($urandom);
        b  = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
        r  = $urandom_range(0, 19);
        ka = (r < 3) ? r + 1 : 0;
        run_branch(ty, 16'($urandom), 16'($urandom), a, b, $urandom_range(0, 3), ka,
                   allow_clr && ($urandom_range(0, 9) == 0), $urandom_range(0, 7) == 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; op_valid = 1'b0; kill = 1'b0; cnt_clr = 1'b0; op_a = '0; op_b = '0;
        bif.br_valid = 1'b0; bif.br_type = '0; bif.br_pc = '0; bif.br_offset = '0;
        step(); step();
        chk("rst_ready", 32'(bif.br_ready), 1);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_redirect", 32'(redirect), 0);
        chk("rst_flush", 32'(flush), 0);
        chk("rst_rpc", 32'(redirect_pc), 0);
        chk("rst_ctrl", 32'(cmp_control), 0);
        chk("rst_d1", 32'(cmp_data_1), 0);
        chk_cnt("rst");
        @(negedge clk); rst = 1'b0;
        step();

        // BEQ taken -> 0x0016
        run_branch(2'b01, 16'h0010, 16'h0005, 16'h1234, 16'h1234, 0, 0, 1'b0, 1'b0);
        chk("beq_target", 32'(redirect_pc), 32'h16);
        // BGT not taken, negative offset
        run_branch(2'b10, 16'h0040, 16'hFFFC, 16'h0003, 16'h0007, 0, 0, 1'b0, 1'b0);
        // Jump after 5-cycle operand wait with PC wrap -> 0x0002
        run_branch(2'b00, 16'hFFFE, 16'h0003, 16'h0001, 16'h0002, 5, 0, 1'b0, 1'b0);
        chk("wrap_target", 32'(redirect_pc), 32'h2);
        // kill in WAIT_OPS, EVAL and first FLUSH cycle; kill coincident with accept
        run_branch(2'b01, 16'h0100, 16'h0010, 16'h0055, 16'h0055, 1, 1, 1'b0, 1'b0);
        run_branch(2'b00, 16'h0200, 16'h0020, 16'h0000, 16'h0000, 0, 2, 1'b0, 1'b0);
        run_branch(2'b11, 16'h0300, 16'h0030, 16'h0001, 16'h0009, 0, 3, 1'b0, 1'b0);
        run_branch(2'b01, 16'h0400, 16'h0001, 16'h0007, 16'h0008, 2, 0, 1'b0, 1'b1);
        // Clear coinciding with a taken EVAL
        run_branch(2'b00, 16'h0500, 16'h0004, 16'h0000, 16'h0000, 0, 0, 1'b1, 1'b0);
        chk("clr_branch_cnt", 32'(branch_cnt), 0);

        // Long run to saturate the counters
        for (int i = 0; i < 340; i++) run_random(1'b0);
        chk("sat_branch_cnt", 32'(branch_cnt), CMAX);
        run_branch(2'b00, 16'h0600, 16'h0001, 16'h0000, 16'h0000, 0, 0, 1'b0, 1'b0);
        chk("sat_hold", 32'(branch_cnt), CMAX);
        for (int i = 0; i < 60; i++) run_random(1'b1);

        // Async reset between edges while in EVAL
        wait_idle();
        bif.br_valid = 1'b1; bif.br_type = 2'b00; bif.br_pc = 16'h1000; bif.br_offset = 16'h0008;
        step();
        bif.br_valid = 1'b0; op_valid = 1'b1; op_a = 16'hAAAA; op_b = 16'h5555;
        step();
        op_valid = 1'b0;
        chk("pre_rst_eval", 32'(cmp_control), 0);
        #2 rst = 1'b1;
        #1;
        m_taken = 0; m_branch = 0; m_rpc = '0;
        chk("arst_ready", 32'(bif.br_ready), 1);
        chk("arst_stall", 32'(stall), 0);
        chk("arst_ctrl", 32'(cmp_control), 0);
        chk("arst_d1", 32'(cmp_data_1), 0);
        chk("arst_d2", 32'(cmp_data_2), 0);
        chk("arst_redirect", 32'(redirect), 0);
        chk("arst_flush", 32'(flush), 0);
        chk("arst_rpc", 32'(redirect_pc), 0);
        chk_cnt("arst");
        @(negedge clk); rst = 1'b0;
        step();
        run_branch(2'b11, 16'h0020, 16'hFFF0, 16'h0001, 16'h0002, 1, 0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Sequencing controller for the 16-bit branch comparator in the execute stage.
- Accepts one branch at a time from decode and stalls until its operands are valid.
- Drives the comparator's data and control inputs for one evaluation cycle, then issues a PC redirect and a timed pipeline flush when the branch is taken.
- Keeps saturating taken and total branch counters for the performance registers.

Parameters:
- DATA_WIDTH, 16, operand, PC and offset width.
- PC_INC, 1, added to the branch PC to form the fall-through base (word addressing).
- FLUSH_CYCLES, 2, cycles `flush` stays high after a taken branch; legal range 1..15.
- CNT_WIDTH, 16, width of the performance counters.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- br_valid  in  1  decode presents a branch.
- br_ready  out  1  controller can accept a branch.
- br_type  in  2  01 EQ, 10 GT, 11 LT, 00 unconditional jump.
- br_pc  in  DATA_WIDTH  PC of the branch instruction.
- br_offset  in  DATA_WIDTH  signed two's-complement offset.
- op_valid  in  1  forwarded operands are valid this cycle.
- op_a, op_b  in  DATA_WIDTH  operands.
- kill  in  1  pipeline-wide abort of the in-flight branch.
- cnt_clr  in  1  synchronous clear of both counters.
- cmp_data_1, cmp_data_2  out  DATA_WIDTH  to comparator data inputs.
- cmp_control  out  2  to comparator control input.
- cmp_branch  in  1  comparator result (combinational, same cycle).
- stall  out  1  freeze the upstream stages.
- redirect  out  1  one-cycle pulse; the fetch stage loads `redirect_pc`.
- redirect_pc  out  DATA_WIDTH  branch target.
- flush  out  1  squash the younger instructions.
- taken_cnt, branch_cnt  out  CNT_WIDTH  performance counters.

Behaviour:
- Reset values (asynchronous, effective immediately): state IDLE, br_ready=1, all other outputs 0, all internal latches 0.
- Handshake: a branch is accepted on a rising edge with br_valid && br_ready. `br_ready` is 1 only in IDLE.
- IDLE:
  - On accept: latch br_type, br_pc, br_offset; go to WAIT_OPS.
- WAIT_OPS:
  - stall=1.
  - When op_valid=1: latch op_a and op_b into the cmp_data registers; go to EVAL.
  - Otherwise wait indefinitely.
  - Operands are never sampled in the accept cycle.
- EVAL (exactly one cycle):
  - stall=1; cmp_control = latched type; cmp_data_1/cmp_data_2 = latched operands.
  - taken = 1 if type==00, else cmp_branch.
  - Target = br_pc + PC_INC + br_offset, truncated mod 2^DATA_WIDTH (wraps, no overflow flag). Register it into redirect_pc.
  - Increment branch_cnt. If taken, also increment taken_cnt.
  - If taken, go to FLUSH; otherwise go to IDLE.
- FLUSH:
  - redirect=1 in the first FLUSH cycle only.
  - flush=1 and stall=1 for FLUSH_CYCLES cycles, counted by an internal down-counter; then go to IDLE.
- cmp_control outside EVAL: forced to 00, so the comparator outputs 0. cmp_data outputs hold their last latched values.
- redirect_pc holds its value until the next taken EVAL.
- Latency: accept at edge t, op_valid high at t+1 → EVAL cycle t+2 → redirect high in cycle t+3 → back in IDLE (br_ready=1) at cycle t+3+FLUSH_CYCLES.
- Not-taken: IDLE at t+3, no redirect, no flush.
- kill:
  - In WAIT_OPS, EVAL or FLUSH: go to IDLE next edge.
  - Counters are not updated if kill coincides with EVAL.
  - If kill arrives during FLUSH, redirect and flush deassert next cycle.
  - kill in IDLE has no effect; an accept in the same cycle is still taken. Priority: rst > kill > normal.
- Counters:
  - Saturate at 2^CNT_WIDTH−1.
  - cnt_clr zeroes both counters. If cnt_clr coincides with an increment, the clear wins (result 0).
- Reset mid-operation: immediate return to IDLE, outputs cleared, pending branch discarded.

Test Plan:
- BEQ taken: type=01, pc=0x0010, offset=0x0005, op_a=op_b=0x1234, op_valid at t+1 → redirect=1 at t+3 with redirect_pc=0x0016; flush high 2 cycles; taken_cnt=1, branch_cnt=1.
- BGT not-taken with negative offset: type=10, op_a=0x0003, op_b=0x0007, offset=0xFFFC → no redirect/flush; br_ready=1 at t+3; branch_cnt=1, taken_cnt=0.
- Operand wait plus wrap-around: op_valid held low 5 cycles → stall stays 1, cmp_control=00 throughout. Then unconditional jump with pc=0xFFFE, offset=0x0003 → redirect_pc=0x0002.
- kill: assert kill in WAIT_OPS → IDLE next cycle, no counter change. Assert kill in the 1st FLUSH cycle → flush=0 the next cycle.
- Counters: preload branch_cnt to 0xFFFF via a long run (or force), evaluate one more branch → stays 0xFFFF. cnt_clr in the same cycle as EVAL → both counters 0.
- Async reset asserted mid-EVAL between clock edges → all outputs 0 and br_ready=1 immediately, without waiting for a clock edge.
